maze_btn_conditioner: RTL and testbench

//  Conditions the five raw board buttons (up/down/left/right/control) before they reach the maze game logic.
//  Per button: 2-FF synchroniser plus asymmetric debounce. One contact burst (10 hi/5 lo x20) = exactly one press.

---
 rtl/maze_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/maze_btn_conditioner.sv | 105 ++++++++++
 tb/tb_maze_btn_conditioner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and button indices for the maze game button front end.
// Direction codes double as the index of the matching button.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int NUM_BTNS    = 5;
    localparam int NUM_DIRS    = 4;
    localparam int BTN_UP      = 0;
    localparam int BTN_DOWN    = 1;
    localparam int BTN_LEFT    = 2;
    localparam int BTN_RIGHT   = 3;
    localparam int BTN_CONTROL = 4;

    function automatic dir_t idx_to_dir(input logic [1:0] idx);
        return dir_t'(idx);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchroniser, asymmetric press/release debounce and rise pulse.
// o_rise is high for the single cycle after the debounced level goes 0->1.
module btn_debounce #(
    parameter int PRESS_CYCLES   = 4,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int MAX_CYCLES = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last;

    // The counter only runs while the synced input disagrees with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        last    = level_q ? RELEASE_LAST : PRESS_LAST;
        if (sync2_q != level_q) begin
            if (cnt_q == last) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= i_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/maze_btn_conditioner.sv
// Debounced button front end: direction presses queue through pending flags into a move FIFO,
// control presses become a one-cycle pulse.
module maze_btn_conditioner
    import maze_pkg::*;
#(
    parameter int PRESS_CYCLES   = 4,
    parameter int RELEASE_CYCLES = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_control,
    output logic       o_move_valid,
    output dir_t       o_move_dir,
    input  logic       i_move_ready,
    output logic       o_control_pulse,
    output logic [4:0] o_btn_level,
    output logic       o_drop
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

    logic [NUM_BTNS-1:0] raw, level, rise;

    assign raw = {i_control, i_right, i_left, i_down, i_up};

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        btn_debounce #(
            .PRESS_CYCLES  (PRESS_CYCLES),
            .RELEASE_CYCLES(RELEASE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (raw[b]),
            .o_level(level[b]),
            .o_rise (rise[b])
        );
    end

    logic [NUM_DIRS-1:0] evt_dir, pending_q, pending_d, req;
    logic [1:0]          sel;
    logic                push, pop, full, can_push;
    logic                drop_q, drop_d, ctrl_q;
    dir_t                mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]     count_q, count_d;

    assign evt_dir      = rise[NUM_DIRS-1:0];
    assign o_move_valid = (count_q != '0);
    assign pop          = o_move_valid & i_move_ready;
    assign full         = (count_q == FULL_CNT);
    // A pop in the same cycle frees the slot the push needs.
    assign can_push     = ~full | pop;

    // Fresh events join the request set directly, so an idle path costs no extra cycle.
    always_comb begin
        req       = pending_q | evt_dir;
        sel       = 2'd0;
        push      = 1'b0;
        pending_d = req;
        for (int i = NUM_DIRS - 1; i >= 0; i--) begin
            if (req[i]) sel = 2'(i);
        end
        if ((req != '0) && can_push) begin
            push           = 1'b1;
            pending_d[sel] = 1'b0;
        end
        drop_d  = |(evt_dir & pending_q);
        count_d = count_q + CNTW'(push) - CNTW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= '0;
            drop_q    <= 1'b0;
            ctrl_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= DIR_UP;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
            ctrl_q    <= rise[BTN_CONTROL];
            count_q   <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= idx_to_dir(sel);
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign o_move_dir      = o_move_valid ? mem_q[rd_ptr_q] : DIR_UP;
    assign o_control_pulse = ctrl_q;
    assign o_btn_level     = level;
    assign o_drop          = drop_q;

endmodule

// File: tb/tb_maze_btn_conditioner.sv
// Directed bench for maze_btn_conditioner: reset, bounce, glitch, simultaneous, backpressure, control.
module tb_maze_btn_conditioner;
    import maze_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_up, i_down, i_left, i_right, i_control;
    logic       o_move_valid;
    dir_t       o_move_dir;
    logic       i_move_ready;
    logic       o_control_pulse;
    logic [4:0] o_btn_level;
    logic       o_drop;

    always #20 clk = ~clk;

    maze_btn_conditioner #(
        .PRESS_CYCLES  (4),
        .RELEASE_CYCLES(16),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_up           (i_up),
        .i_down         (i_down),
        .i_left         (i_left),
        .i_right        (i_right),
        .i_control      (i_control),
        .o_move_valid   (o_move_valid),
        .o_move_dir     (o_move_dir),
        .i_move_ready   (i_move_ready),
        .o_control_pulse(o_control_pulse),
        .o_btn_level    (o_btn_level),
        .o_drop         (o_drop)
    );

    int         total = 0;
    int         bad = 0;
    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];
    int         ctrl_cnt = 0;
    int         wide_cnt = 0;
    int         drop_cnt = 0;
    logic       ctrl_prev = 1'b0;

    // Observes handshakes and pulses mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            if (o_move_valid && i_move_ready) got_q.push_back(o_move_dir);
            if (o_control_pulse) ctrl_cnt <= ctrl_cnt + 1;
            if (o_control_pulse && ctrl_prev) wide_cnt <= wide_cnt + 1;
            if (o_drop) drop_cnt <= drop_cnt + 1;
        end
        ctrl_prev <= o_control_pulse;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_beats(input string tag, input int base);
        chk({tag, "_n"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) chk({tag, "_dir"}, got_q[base + i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        int base;
        int dbase;
        int cbase;

        rst = 1'b0;
        {i_up, i_down, i_left, i_right, i_control} = 5'b0;
        i_move_ready = 1'b0;

        // Reset with buttons toggling
        for (int i = 0; i < 3; i++) begin
            {i_up, i_down, i_left, i_right, i_control} = ~{i_up, i_down, i_left, i_right, i_control};
            step(1);
            chk("rst_outputs", {o_move_valid, o_move_dir, o_control_pulse, o_btn_level, o_drop}, 0);
        end
        rst = 1'b1;
        {i_up, i_down, i_left, i_right, i_control} = ~{i_up, i_down, i_left, i_right, i_control};
        step(1);
        chk("post_rst_outputs", {o_move_valid, o_move_dir, o_control_pulse, o_btn_level, o_drop}, 0);
        {i_up, i_down, i_left, i_right, i_control} = 5'b0;
        step(20);

        // Reset arriving mid-press discards it
        i_move_ready = 1'b1;
        base = got_q.size();
        i_up = 1'b1;
        step(5);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        i_up = 1'b0;
        step(20);
        chk("midrst_beats", got_q.size() - base, 0);
        chk("midrst_level", o_btn_level, 0);

        // Bounce: 10 hi / 5 lo x20 gives one press
        base = got_q.size();
        i_up = 1'b1;
        step(6);
        chk("bnc_lat6_valid", o_move_valid, 0);
        step(1);
        chk("bnc_lat7_valid", o_move_valid, 1);
        chk("bnc_lat7_dir", o_move_dir, DIR_UP);
        step(3);
        i_up = 1'b0;
        step(5);
        for (int r = 1; r < 20; r++) begin
            i_up = 1'b1;
            step(10);
            i_up = 1'b0;
            if (r < 19) step(5);
        end
        step(17);
        chk("bnc_rel17_level", o_btn_level[0], 1);
        step(1);
        chk("bnc_rel18_level", o_btn_level[0], 0);
        step(5);
        exp_q.push_back(DIR_UP);
        chk_beats("bnc_beats", base);

        // Glitch: 3 cycles is one short of a press
        base = got_q.size();
        i_right = 1'b1;
        step(3);
        i_right = 1'b0;
        step(10);
        chk("glitch_level", o_btn_level, 0);
        chk("glitch_valid", o_move_valid, 0);
        chk("glitch_beats", got_q.size() - base, 0);

        // Simultaneous direction presses drain in priority order
        dbase = drop_cnt;
        {i_up, i_down, i_left, i_right} = 4'hf;
        step(6);
        chk("sim_lat6_valid", o_move_valid, 0);
        step(1);
        chk("sim_b0", {o_move_valid, o_move_dir}, {1'b1, DIR_UP});
        step(1);
        chk("sim_b1", {o_move_valid, o_move_dir}, {1'b1, DIR_DOWN});
        step(1);
        chk("sim_b2", {o_move_valid, o_move_dir}, {1'b1, DIR_LEFT});
        step(1);
        chk("sim_b3", {o_move_valid, o_move_dir}, {1'b1, DIR_RIGHT});
        step(1);
        chk("sim_empty", o_move_valid, 0);
        chk("sim_level", o_btn_level, 5'b01111);
        {i_up, i_down, i_left, i_right} = 4'h0;
        step(20);
        chk("sim_nodrop", drop_cnt - dbase, 0);

        // Backpressure: full FIFO holds pending, re-press drops
        i_move_ready = 1'b0;
        dbase = drop_cnt;
        for (int k = 0; k < 4; k++) begin
            i_right = 1'b1;
            step(8);
            i_right = 1'b0;
            step(20);
        end
        {i_up, i_down} = 2'b11;
        step(8);
        {i_up, i_down} = 2'b00;
        step(20);
        chk("bp_full_head", {o_move_valid, o_move_dir}, {1'b1, DIR_RIGHT});
        chk("bp_nodrop", drop_cnt - dbase, 0);
        i_up = 1'b1;
        step(6);
        chk("bp_drop_lat6", o_drop, 0);
        step(1);
        chk("bp_drop_lat7", o_drop, 1);
        step(1);
        chk("bp_drop_lat8", o_drop, 0);
        i_up = 1'b0;
        step(20);
        chk("bp_drop_count", drop_cnt - dbase, 1);
        chk("bp_head_stable", {o_move_valid, o_move_dir}, {1'b1, DIR_RIGHT});
        base = got_q.size();
        i_move_ready = 1'b1;
        step(10);
        exp_q.push_back(DIR_RIGHT);
        exp_q.push_back(DIR_RIGHT);
        exp_q.push_back(DIR_RIGHT);
        exp_q.push_back(DIR_RIGHT);
        exp_q.push_back(DIR_UP);
        exp_q.push_back(DIR_DOWN);
        chk_beats("bp_drain", base);
        chk("bp_empty", o_move_valid, 0);

        // Control bursts become single pulses and never touch the FIFO
        i_move_ready = 1'b0;
        cbase = ctrl_cnt;
        dbase = drop_cnt;
        for (int k = 0; k < 3; k++) begin
            i_control = 1'b1;
            if (k == 0) begin
                step(6);
                chk("ctrl_lat6", o_control_pulse, 0);
                step(1);
                chk("ctrl_lat7", o_control_pulse, 1);
                step(1);
                chk("ctrl_lat8", o_control_pulse, 0);
                step(12);
            end else begin
                step(20);
            end
            i_control = 1'b0;
            step(20);
        end
        chk("ctrl_count", ctrl_cnt - cbase, 3);
        chk("ctrl_width", wide_cnt, 0);
        chk("ctrl_fifo", o_move_valid, 0);
        chk("ctrl_nodrop", drop_cnt - dbase, 0);
        chk("final_level", o_btn_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
